// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite renderer: sprite bitmap ROM, motion FSM
// states, default screen geometry and per-sprite state record.
package sprite_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int RGB_W_MAX    = 24;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } motion_state_t;

  // rgb is sized for the widest colour depth; only the low 3*CDEPTH bits are used.
  typedef struct packed {
    logic                 en;
    logic [9:0]           x;
    logic [9:0]           y;
    logic [3:0]           dx;
    logic [3:0]           dy;
    logic [RGB_W_MAX-1:0] rgb;
  } sprite_t;

  // Rounded blob, indexed [row][col], bit 15 = col 15.
  localparam logic [15:0] SHAPE [16] = '{
    16'h07E0, 16'h1FF8, 16'h3FFC, 16'h7FFE,
    16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFE,
    16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h07E0
  };

  function automatic logic shape_bit(input logic [3:0] row, input logic [3:0] col);
    return SHAPE[row][col];
  endfunction

endpackage

// File: rtl/sprite_motion.sv
// Single-axis bounce step: next position/velocity for one sprite coordinate,
// reflecting off 0 and off the supplied upper limit.
module sprite_motion (
  input  logic [9:0] pos,
  input  logic [3:0] vel,
  input  logic [9:0] limit,
  output logic [9:0] pos_nxt,
  output logic [3:0] vel_nxt
);

  logic signed [10:0] n;

  always_comb begin
    n       = signed'({1'b0, pos}) + signed'({{7{vel[3]}}, vel});
    pos_nxt = n[9:0];
    vel_nxt = vel;
    if (n[10]) begin
      pos_nxt = '0;
      vel_nxt = 4'd0 - vel;
    end else if (n[9:0] > limit) begin
      pos_nxt = limit;
      vel_nxt = 4'd0 - vel;
    end
  end

endmodule

// File: rtl/sprite_engine.sv
// NSPR-sprite renderer with per-frame bounce motion and index-priority
// compositing. Define SPRITE_COLLISION_EN to build the overlap detector.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int NSPR     = 4,
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int CDEPTH   = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                  px_clk,
  input  logic                  rstn,
  input  logic [9:0]            x_px,
  input  logic [9:0]            y_px,
  input  logic                  activevideo,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_idx,
  input  logic                  cfg_en,
  input  logic [9:0]            cfg_x,
  input  logic [9:0]            cfg_y,
  input  logic [3:0]            cfg_dx,
  input  logic [3:0]            cfg_dy,
  input  logic [3*CDEPTH-1:0]   cfg_rgb,
  input  logic [3*CDEPTH-1:0]   bg_rgb,
  output logic [CDEPTH-1:0]     r_out,
  output logic [CDEPTH-1:0]     g_out,
  output logic [CDEPTH-1:0]     b_out,
  output logic                  frame_tick,
  output logic                  collision,
  output motion_state_t         dbg_state
);

  localparam int         RGB_W  = 3 * CDEPTH;
  localparam logic [9:0] SPR_WV = 10'(SPR_W);
  localparam logic [9:0] SPR_HV = 10'(SPR_H);
  localparam logic [9:0] X_LIM  = 10'(H_ACTIVE - SPR_W);
  localparam logic [9:0] Y_LIM  = 10'(V_ACTIVE - SPR_H);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_BLNK = 10'(V_ACTIVE);
  localparam logic [2:0] IDX_LAST = 3'(NSPR - 1);

  sprite_t            spr [NSPR];
  motion_state_t      state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [9:0]         y_q;
  logic               tick_cond;

  logic [9:0]         rel_x [NSPR];
  logic [9:0]         rel_y [NSPR];
  logic [NSPR-1:0]    opq_d, opq_q;
  logic               av_q;
  logic [RGB_W-1:0]   bg_q;
  logic [RGB_W-1:0]   pix_d, pix_q;

  sprite_t            cur;
  logic [9:0]         mx_pos, my_pos;
  logic [3:0]         mx_vel, my_vel;
  logic [RGB_W_MAX-1:0] rgb_wr;

  assign dbg_state = state_q;

  // ---------------- frame tick ----------------
  assign tick_cond = (y_q == V_LAST) && (y_px == V_BLNK);

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      y_q        <= '0;
      frame_tick <= 1'b0;
    end else begin
      y_q        <= y_px;
      frame_tick <= tick_cond;
    end
  end

  // ---------------- motion FSM ----------------
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        if (idx_q == IDX_LAST) state_d = IDLE;
        else                   idx_d   = idx_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < NSPR; i++) begin
      if (idx_q == 3'(i)) cur = spr[i];
    end
  end

  sprite_motion u_motion_x (
    .pos     (cur.x),
    .vel     (cur.dx),
    .limit   (X_LIM),
    .pos_nxt (mx_pos),
    .vel_nxt (mx_vel)
  );

  sprite_motion u_motion_y (
    .pos     (cur.y),
    .vel     (cur.dy),
    .limit   (Y_LIM),
    .pos_nxt (my_pos),
    .vel_nxt (my_vel)
  );

  always_comb begin
    rgb_wr            = '0;
    rgb_wr[RGB_W-1:0] = cfg_rgb;
  end

  // A config write to the sprite under update wins and cancels its motion step.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NSPR; i++) spr[i] <= '0;
    end else begin
      for (int i = 0; i < NSPR; i++) begin
        if (cfg_we && (cfg_idx == 3'(i))) begin
          spr[i].en  <= cfg_en;
          spr[i].x   <= cfg_x;
          spr[i].y   <= cfg_y;
          spr[i].dx  <= cfg_dx;
          spr[i].dy  <= cfg_dy;
          spr[i].rgb <= rgb_wr;
        end else if ((state_q == UPDATE) && (idx_q == 3'(i)) && spr[i].en) begin
          spr[i].x  <= mx_pos;
          spr[i].dx <= mx_vel;
          spr[i].y  <= my_pos;
          spr[i].dy <= my_vel;
        end
      end
    end
  end

  // ---------------- stage 1: hit test ----------------
  // Unsigned differences wrap for pixels left of / above a sprite, so they miss.
  always_comb begin
    for (int i = 0; i < NSPR; i++) begin
      rel_x[i] = x_px - spr[i].x;
      rel_y[i] = y_px - spr[i].y;
      opq_d[i] = spr[i].en && (rel_x[i] < SPR_WV) && (rel_y[i] < SPR_HV) &&
                 shape_bit(rel_y[i][3:0], rel_x[i][3:0]);
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      opq_q <= '0;
      av_q  <= 1'b0;
      bg_q  <= '0;
    end else begin
      opq_q <= opq_d;
      av_q  <= activevideo;
      bg_q  <= bg_rgb;
    end
  end

  // ---------------- stage 2: priority compositing ----------------
  always_comb begin
    pix_d = bg_q;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (opq_q[i]) pix_d = spr[i].rgb[RGB_W-1:0];
    end
    if (!av_q) pix_d = '0;
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) pix_q <= '0;
    else       pix_q <= pix_d;
  end

  assign r_out = pix_q[3*CDEPTH-1:2*CDEPTH];
  assign g_out = pix_q[2*CDEPTH-1:CDEPTH];
  assign b_out = pix_q[CDEPTH-1:0];

  // ---------------- optional overlap detector ----------------
`ifdef SPRITE_COLLISION_EN
  logic multi;
  logic seen;
  logic coll_acc;
  logic collision_q;

  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NSPR; i++) begin
      if (opq_d[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    multi = multi && activevideo;
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      coll_acc    <= 1'b0;
      collision_q <= 1'b0;
    end else if (frame_tick) begin
      collision_q <= coll_acc;
      coll_acc    <= multi;
    end else begin
      coll_acc    <= coll_acc | multi;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: rendering, priority, blanking, bounce
// motion, config/update race and mid-update reset.
module tb_sprite_engine;
  import sprite_pkg::*;

  logic          px_clk = 1'b0;
  logic          rstn;
  logic [9:0]    x_px, y_px;
  logic          activevideo;
  logic          cfg_we;
  logic [2:0]    cfg_idx;
  logic          cfg_en;
  logic [9:0]    cfg_x, cfg_y;
  logic [3:0]    cfg_dx, cfg_dy;
  logic [11:0]   cfg_rgb, bg_rgb;
  logic [3:0]    r_out, g_out, b_out;
  logic          frame_tick;
  logic          collision;
  motion_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  localparam logic [11:0] RED = 12'hF00, GRN = 12'h0F0, BLU = 12'h00F;
  localparam logic [11:0] CYN = 12'h0FF, YEL = 12'hFF0;

  sprite_engine dut (
    .px_clk      (px_clk),
    .rstn        (rstn),
    .x_px        (x_px),
    .y_px        (y_px),
    .activevideo (activevideo),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_en      (cfg_en),
    .cfg_x       (cfg_x),
    .cfg_y       (cfg_y),
    .cfg_dx      (cfg_dx),
    .cfg_dy      (cfg_dy),
    .cfg_rgb     (cfg_rgb),
    .bg_rgb      (bg_rgb),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .frame_tick  (frame_tick),
    .collision   (collision),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 px_clk = ~px_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking / drivers ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; drives for one clock.
  task automatic cfg_write(input logic [2:0] idx, input logic en, input logic [9:0] x,
                           input logic [9:0] y, input logic [3:0] dx, input logic [3:0] dy,
                           input logic [11:0] rgb);
    cfg_idx = idx; cfg_en = en; cfg_x = x; cfg_y = y;
    cfg_dx = dx; cfg_dy = dy; cfg_rgb = rgb; cfg_we = 1'b1;
    @(negedge px_clk);
    cfg_we = 1'b0;
  endtask

  // Present a coordinate and check the colour two clocks later.
  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic av, input logic [11:0] expv);
    x_px = x; y_px = y; activevideo = av;
    @(negedge px_clk);
    @(negedge px_clk);
    check(tag, {4'h0, r_out, g_out, b_out}, {4'h0, expv});
  endtask

  // Drive a 479->480 row transition and let the motion pass run. With wr2 set,
  // sprite 2 is written in the cycle the FSM is updating it (3 clocks after the tick).
  task automatic frame(input bit wr2, input logic [9:0] wx, input logic [9:0] wy);
    activevideo = 1'b0; x_px = '0; y_px = 10'd479;
    @(negedge px_clk);
    y_px = 10'd480;
    @(negedge px_clk);
    check("frame_tick_hi", {15'd0, frame_tick}, 16'd1);
    @(negedge px_clk);
    check("frame_tick_lo", {15'd0, frame_tick}, 16'd0);
    check("fsm_update", {15'd0, dbg_state}, {15'd0, UPDATE});
    @(negedge px_clk);
    @(negedge px_clk);
    if (wr2) cfg_write(3'd2, 1'b1, wx, wy, 4'd5, 4'd5, YEL);
    else     @(negedge px_clk);
    repeat (6) @(negedge px_clk);
    check("fsm_idle", {15'd0, dbg_state}, {15'd0, IDLE});
    y_px = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn = 1'b0; x_px = '0; y_px = '0; activevideo = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_x = '0; cfg_y = '0;
    cfg_dx = '0; cfg_dy = '0; cfg_rgb = '0; bg_rgb = BLU;
    repeat (3) @(negedge px_clk);
    check("rst_rgb", {4'h0, r_out, g_out, b_out}, 16'h0000);
    check("rst_tick", {15'd0, frame_tick}, 16'd0);
    check("rst_coll", {15'd0, collision}, 16'd0);
    check("rst_fsm", {15'd0, dbg_state}, {15'd0, IDLE});
    rstn = 1'b1;
    @(negedge px_clk);

    // Single sprite at (100,50)
    cfg_write(3'd0, 1'b1, 10'd100, 10'd50, 4'd0, 4'd0, RED);
    pix("s0_r0c0",   10'd100, 10'd50, 1'b1, BLU);
    pix("s0_r0c5",   10'd105, 10'd50, 1'b1, RED);
    // latency: the new coordinate's colour is not yet visible after one clock
    x_px = 10'd99; y_px = 10'd55;
    @(negedge px_clk);
    check("lat_1clk", {4'h0, r_out, g_out, b_out}, {4'h0, RED});
    @(negedge px_clk);
    check("lat_2clk_leftwrap", {4'h0, r_out, g_out, b_out}, {4'h0, BLU});
    pix("s0_r7c0",   10'd100, 10'd57, 1'b1, RED);
    pix("s0_r15c15", 10'd115, 10'd65, 1'b1, BLU);
    pix("s0_right",  10'd116, 10'd50, 1'b1, BLU);
    pix("s0_r8c8",   10'd108, 10'd58, 1'b1, RED);
    pix("s0_above",  10'd105, 10'd49, 1'b1, BLU);

    // Blanking
    pix("blank_x700", 10'd700, 10'd50, 1'b0, 12'h000);
    pix("blank_spr",  10'd105, 10'd50, 1'b0, 12'h000);

    // Priority: sprite 1 green alone, then sprite 0 red on top
    cfg_write(3'd1, 1'b1, 10'd200, 10'd200, 4'd0, 4'd0, GRN);
    pix("s1_alone", 10'd205, 10'd200, 1'b1, GRN);
    cfg_write(3'd0, 1'b1, 10'd200, 10'd200, 4'd0, 4'd0, RED);
    pix("prio_red",  10'd205, 10'd200, 1'b1, RED);
    pix("prio_bg",   10'd200, 10'd200, 1'b1, BLU);
    frame(1'b0, '0, '0);
`ifdef SPRITE_COLLISION_EN
    check("coll_set", {15'd0, collision}, 16'd1);
`else
    check("coll_off", {15'd0, collision}, 16'd0);
`endif
    cfg_write(3'd1, 1'b1, 10'd400, 10'd400, 4'd0, 4'd0, GRN);
    frame(1'b0, '0, '0);
    check("coll_clear", {15'd0, collision}, 16'd0);
    pix("s1_moved", 10'd405, 10'd400, 1'b1, GRN);

    // Bounce: x=622 dx=+3 -> 624,-3 ; y=1 dy=-2 -> 0,+2
    cfg_write(3'd3, 1'b1, 10'd622, 10'd1, 4'd3, 4'hE, CYN);
    frame(1'b0, '0, '0);
    pix("bnc1_x624_c4", 10'd628, 10'd0, 1'b1, BLU);
    pix("bnc1_x624_c5", 10'd629, 10'd0, 1'b1, CYN);
    pix("bnc1_y0",      10'd634, 10'd0, 1'b1, CYN);
    frame(1'b0, '0, '0);
    pix("bnc2_x621_c5",  10'd626, 10'd2, 1'b1, CYN);
    pix("bnc2_x621_c15", 10'd636, 10'd2, 1'b1, BLU);
    pix("bnc2_y2_r15",   10'd630, 10'd17, 1'b1, CYN);

    // Config write races the update of sprite 2
    cfg_write(3'd2, 1'b1, 10'd300, 10'd300, 4'd5, 4'd5, YEL);
    frame(1'b1, 10'd310, 10'd320);
    pix("race_r0c5", 10'd315, 10'd320, 1'b1, YEL);
    pix("race_r7c0", 10'd310, 10'd327, 1'b1, YEL);
    pix("race_r0c0", 10'd310, 10'd320, 1'b1, BLU);

    // Reset in the middle of the motion pass
    activevideo = 1'b0; x_px = '0; y_px = 10'd479;
    @(negedge px_clk);
    y_px = 10'd480;
    @(negedge px_clk);
    @(negedge px_clk);
    check("pre_rst_update", {15'd0, dbg_state}, {15'd0, UPDATE});
    rstn = 1'b0;
    #1;
    check("mid_rst_rgb", {4'h0, r_out, g_out, b_out}, 16'h0000);
    check("mid_rst_fsm", {15'd0, dbg_state}, {15'd0, IDLE});
    check("mid_rst_tick", {15'd0, frame_tick}, 16'd0);
    check("mid_rst_coll", {15'd0, collision}, 16'd0);
    @(negedge px_clk);
    rstn = 1'b1;
    x_px = 10'd315; y_px = 10'd320; activevideo = 1'b1;
    @(negedge px_clk);
    check("post_rst_lat1", {4'h0, r_out, g_out, b_out}, 16'h0000);
    @(negedge px_clk);
    check("post_rst_bg", {4'h0, r_out, g_out, b_out}, {4'h0, BLU});
    pix("post_rst_s0_off", 10'd205, 10'd200, 1'b1, BLU);
    repeat (6) @(negedge px_clk);
    check("post_rst_idle", {15'd0, dbg_state}, {15'd0, IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
